// File: rtl/bottling_line_sequencer.sv
// bottling_line_sequencer: fill/cork line FSM with cork stock, dozen tally and box count
module bottling_line_sequencer #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CORK_MAX = 99,
  parameter int DOZEN = 12,
  parameter int BOX_MAX = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       pg,
  input  logic       ch,
  input  logic       ro,
  input  logic       cq,
  input  logic       eb,
  input  logic       refill,
  output logic       motor,
  output logic       ev,
  output logic       ve,
  output logic       alarme,
  output logic [6:0] cork_count,
  output logic [3:0] dozen_count,
  output logic [6:0] box_count,
  output logic       dozen_done,
  output logic [2:0] state
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  typedef enum logic [2:0] {
    IDLE = 3'd0, ADVANCE = 3'd1, FILL = 3'd2, CAP = 3'd3,
    INSPECT = 3'd4, EJECT = 3'd5, ALARM = 3'd6
  } state_t;
  state_t cur, nxt;
  logic [TW-1:0] timer;
  logic waiting, exit_cond, timed_out, corked, good, box_full;
  always_comb begin
    waiting = (cur == ADVANCE) || (cur == FILL) || (cur == CAP) || (cur == EJECT);
    exit_cond = (cur == ADVANCE) ? pg : (cur == FILL) ? ch : (cur == CAP) ? ro : (cur == EJECT) ? eb : 1'b0;
    timed_out = waiting && !exit_cond && (timer == TW'(TIMEOUT_CYCLES - 1));
    nxt = cur;
    if (cur == ALARM) nxt = enable ? ALARM : IDLE;
    else if (!enable) nxt = IDLE;
    else if (timed_out) nxt = ALARM;
    else
      case (cur)
        IDLE:    nxt = ADVANCE;
        ADVANCE: nxt = pg ? FILL : ADVANCE;
        FILL:    nxt = !ch ? FILL : (cork_count != 7'd0) ? CAP : ALARM;
        CAP:     nxt = ro ? INSPECT : CAP;
        INSPECT: nxt = cq ? ADVANCE : EJECT;
        EJECT:   nxt = eb ? ADVANCE : EJECT;
        default: nxt = IDLE;
      endcase
    corked = (cur == CAP) && (nxt == INSPECT);
    good = (cur == INSPECT) && (nxt == ADVANCE);
    box_full = dozen_count == 4'(DOZEN - 1);
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cur <= IDLE;
      timer <= '0;
      cork_count <= 7'(CORK_MAX);
      dozen_count <= '0;
      box_count <= '0;
      dozen_done <= 1'b0;
    end else begin
      cur <= nxt;
      timer <= (nxt != cur || !waiting) ? '0 : timer + TW'(1);
      cork_count <= refill ? 7'(CORK_MAX) : corked ? cork_count - 7'd1 : cork_count;
      dozen_done <= good && box_full;
      if (good) begin
        dozen_count <= box_full ? 4'd0 : dozen_count + 4'd1;
        if (box_full) box_count <= (box_count == 7'(BOX_MAX)) ? 7'd0 : box_count + 7'd1;
      end
    end
  assign motor = (cur == ADVANCE) || (cur == EJECT);
  assign ev = cur == FILL;
  assign ve = cur == CAP;
  assign alarme = cur == ALARM;
  assign state = cur;
endmodule

// File: tb/tb_bottling_line_sequencer.sv
// tb_bottling_line_sequencer: random stimulus on two parameterisations against a stage-level model
module tb_bottling_line_sequencer;
  logic clock = 1'b0;
  logic reset, enable, pg, ch, ro, cq, eb, refill;
  logic motor[2], ev[2], ve[2], alarme[2], dozen_done[2];
  logic [6:0] cork_count[2], box_count[2];
  logic [3:0] dozen_count[2];
  logic [2:0] state[2];
  int n_tests = 0, n_fail = 0;
  int ms[2], mw[2], mc[2], md[2], mb[2], mdd[2];
  int cmax[2] = '{99, 20};
  int tmo[2] = '{50000, 16};
  int bmax[2] = '{99, 3};
  always #5 clock = ~clock;
  bottling_line_sequencer u0 (
    .clock(clock), .reset(reset), .enable(enable), .pg(pg), .ch(ch), .ro(ro), .cq(cq), .eb(eb),
    .refill(refill), .motor(motor[0]), .ev(ev[0]), .ve(ve[0]), .alarme(alarme[0]),
    .cork_count(cork_count[0]), .dozen_count(dozen_count[0]), .box_count(box_count[0]),
    .dozen_done(dozen_done[0]), .state(state[0])
  );
  bottling_line_sequencer #(.TIMEOUT_CYCLES(16), .CORK_MAX(20), .DOZEN(12), .BOX_MAX(3)) u1 (
    .clock(clock), .reset(reset), .enable(enable), .pg(pg), .ch(ch), .ro(ro), .cq(cq), .eb(eb),
    .refill(refill), .motor(motor[1]), .ev(ev[1]), .ve(ve[1]), .alarme(alarme[1]),
    .cork_count(cork_count[1]), .dozen_count(dozen_count[1]), .box_count(box_count[1]),
    .dozen_done(dozen_done[1]), .state(state[1])
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      ms[k] = 0; mw[k] = 0; mc[k] = cmax[k]; md[k] = 0; mb[k] = 0; mdd[k] = 0;
    end
  endtask
  // stage codes: 0 idle, 1 advance, 2 fill, 3 cap, 4 inspect, 5 eject, 6 alarm
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int s, ns, sens;
      bit good_b;
      s = ms[k];
      good_b = 0;
      sens = (s == 1) ? int'(pg) : (s == 2) ? int'(ch) : (s == 3) ? int'(ro) : (s == 5) ? int'(eb) : 0;
      if (s == 6) ns = enable ? 6 : 0;
      else if (!enable) ns = 0;
      else if (s == 0) ns = 1;
      else if (s == 4) begin ns = cq ? 1 : 5; good_b = cq; end
      else if (sens != 0) ns = (s == 2 && mc[k] == 0) ? 6 : (s == 5) ? 1 : s + 1;
      else ns = (mw[k] == tmo[k] - 1) ? 6 : s;
      mdd[k] = 0;
      if (good_b) begin
        md[k]++;
        if (md[k] == 12) begin
          md[k] = 0;
          mdd[k] = 1;
          mb[k] = (mb[k] == bmax[k]) ? 0 : mb[k] + 1;
        end
      end
      if (s == 3 && ns == 4) mc[k]--;
      if (refill) mc[k] = cmax[k];
      mw[k] = (ns == s) ? mw[k] + 1 : 0;
      ms[k] = ns;
    end
  endtask
  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d state", k), 32'(state[k]), ms[k]);
      check($sformatf("u%0d motor", k), 32'(motor[k]), 32'(ms[k] == 1 || ms[k] == 5));
      check($sformatf("u%0d ev", k), 32'(ev[k]), 32'(ms[k] == 2));
      check($sformatf("u%0d ve", k), 32'(ve[k]), 32'(ms[k] == 3));
      check($sformatf("u%0d alarme", k), 32'(alarme[k]), 32'(ms[k] == 6));
      check($sformatf("u%0d cork_count", k), 32'(cork_count[k]), mc[k]);
      check($sformatf("u%0d dozen_count", k), 32'(dozen_count[k]), md[k]);
      check($sformatf("u%0d box_count", k), 32'(box_count[k]), mb[k]);
      check($sformatf("u%0d dozen_done", k), 32'(dozen_done[k]), mdd[k]);
    end
  endtask
  initial begin
    reset = 1'b1;
    {enable, pg, ch, ro, cq, eb, refill} = '0;
    model_reset();
    @(negedge clock);
    check_all();
    reset = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(1999) == 0) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 reset = 1'b0;
      end
      enable = $urandom_range(63) != 0;
      pg = $urandom_range(4) == 0;
      ch = $urandom_range(4) == 0;
      ro = $urandom_range(4) == 0;
      eb = $urandom_range(4) == 0;
      cq = $urandom_range(3) != 0;
      refill = $urandom_range(399) == 0;
      model_step();
      @(negedge clock);
      check_all();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
